// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words over valid/ready and serialises them one bit
// per clock. A one-entry holding buffer lets back-to-back words stream with no idle gap.
// Optional build macro SERIAL_FEEDER_PARITY_EN appends an even-parity bit to every frame.
module serial_word_feeder #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_start,
   output logic             busy,
   output logic [15:0]      words_sent
);

`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
   localparam int unsigned FRAME_LEN = WIDTH;
`endif
   localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);
`endif

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ser_out_q, ser_out_d;
   logic               ser_valid_q, ser_valid_d;
   logic               word_start_q, word_start_d;
   logic               load_ready_q, load_ready_d;
   logic               busy_q, busy_d;
   logic [15:0]        words_sent_q, words_sent_d;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic               accept;
   logic               frame_end;
   logic               load_word;
   logic [WIDTH-1:0]   load_src;

   // Handshake and frame-boundary decode
   always_comb begin
      accept    = load_valid & load_ready_q;
      frame_end = (state_q == StShift) && (cnt_q == LAST_CNT);
   end

   // Next-state logic: frame sequencing, holding buffer and output bit selection
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      cnt_d        = cnt_q;
      ser_out_d    = ser_out_q;
      ser_valid_d  = ser_valid_q;
      word_start_d = 1'b0;
      words_sent_d = words_sent_q;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d     = parity_q;
`endif
      load_word    = 1'b0;
      load_src     = load_data;

      case (state_q)
         StIdle: begin
            // Idle: an accepted word bypasses the holding buffer
            if (accept) begin
               load_word = 1'b1;
            end
         end
         StShift: begin
            if (frame_end) begin
               words_sent_d = words_sent_q + 16'd1;
               if (hold_full_q) begin
                  load_word   = 1'b1;
                  load_src    = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  load_word = 1'b1;
               end else begin
                  state_d     = StIdle;
                  ser_valid_d = 1'b0;
                  ser_out_d   = IDLE_BIT;
               end
            end else begin
               // Advance one bit; shift_q keeps the current bit in its outgoing slot
               shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
               cnt_d   = cnt_q + 1'b1;
               ser_out_d = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
`ifdef SERIAL_FEEDER_PARITY_EN
               if (cnt_q == DATA_CNT) begin
                  ser_out_d = parity_q;
               end
`endif
               if (accept) begin
                  hold_d      = load_data;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: begin
            state_d     = StIdle;
            ser_valid_d = 1'b0;
            ser_out_d   = IDLE_BIT;
         end
      endcase

      // Start a new frame: first bit is driven the cycle after the loading edge
      if (load_word) begin
         state_d      = StShift;
         shift_d      = load_src;
         cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
         ser_out_d    = MSB_FIRST ? load_src[WIDTH-1] : load_src[0];
         ser_valid_d  = 1'b1;
         word_start_d = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_d     = ^load_src;
`endif
      end

      load_ready_d = ~hold_full_d;
      busy_d       = (state_d == StShift) | hold_full_d;
   end

   // State and registered outputs; asynchronous reset discards any frame in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         cnt_q        <= '0;
         ser_out_q    <= IDLE_BIT;
         ser_valid_q  <= 1'b0;
         word_start_q <= 1'b0;
         load_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         words_sent_q <= 16'd0;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         cnt_q        <= cnt_d;
         ser_out_q    <= ser_out_d;
         ser_valid_q  <= ser_valid_d;
         word_start_q <= word_start_d;
         load_ready_q <= load_ready_d;
         busy_q       <= busy_d;
         words_sent_q <= words_sent_d;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign load_ready = load_ready_q;
   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign word_start = word_start_q;
   assign busy       = busy_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
`timescale 1ns/1ps
// Bench for serial_word_feeder: an MSB-first and an LSB-first instance share all inputs and
// are checked every cycle against a queue model of the expected bit stream.
module tb_serial_word_feeder;

   localparam int unsigned W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int unsigned FLEN = W + 1;
`else
   localparam int unsigned FLEN = W;
`endif

   logic          clock;
   logic          reset;
   logic [W-1:0]  load_data;
   logic          load_valid;

   logic          rdy_m, out_m, val_m, ws_m, busy_m;
   logic [15:0]   cnt_m;
   logic          rdy_l, out_l, val_l, ws_l, busy_l;
   logic [15:0]   cnt_l;

   serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut_msb (
      .clock      (clock),
      .reset      (reset),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (rdy_m),
      .ser_out    (out_m),
      .ser_valid  (val_m),
      .word_start (ws_m),
      .busy       (busy_m),
      .words_sent (cnt_m)
   );

   serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
      .clock      (clock),
      .reset      (reset),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (rdy_l),
      .ser_out    (out_l),
      .ser_valid  (val_l),
      .word_start (ws_l),
      .busy       (busy_l),
      .words_sent (cnt_l)
   );

   always #5 clock = ~clock;

   // Model: every bit still to appear on the line, front = bit currently displayed
   typedef struct {
      logic bm;
      logic bl;
      logic st;
      logic last;
   } item_t;

   item_t       q[$];
   logic [15:0] m_words;
   int          tests;
   int          fails;

   function automatic void push_word(input logic [W-1:0] w);
      item_t it;
      for (int i = 0; i < int'(FLEN); i++) begin
         if (i < int'(W)) begin
            it.bm = w[W-1-i];
            it.bl = w[i];
         end else begin
            it.bm = ($countones(w) % 2) == 1;
            it.bl = it.bm;
         end
         it.st   = (i == 0);
         it.last = (i == int'(FLEN) - 1);
         q.push_back(it);
      end
   endfunction

   function automatic logic [41:0] exp_now();
      logic v, om, ol, st, rdy;
      v   = q.size() > 0;
      om  = 1'b1;
      ol  = 1'b1;
      st  = 1'b0;
      if (v) begin
         om = q[0].bm;
         ol = q[0].bl;
         st = q[0].st;
      end
      rdy = q.size() <= int'(FLEN);
      return {v, om, st, rdy, v, m_words, v, ol, st, rdy, v, m_words};
   endfunction

   function automatic logic [41:0] obs_now();
      return {val_m, out_m, ws_m, rdy_m, busy_m, cnt_m, val_l, out_l, ws_l, rdy_l, busy_l, cnt_l};
   endfunction

   // Advance one clock; model retires the displayed bit then appends any accepted word
   task automatic step();
      logic acc;
      acc = load_valid && (q.size() <= int'(FLEN)) && (reset === 1'b1);
      @(posedge clock);
      if (reset === 1'b1) begin
         if (q.size() > 0) begin
            if (q[0].last) m_words = m_words + 16'd1;
            void'(q.pop_front());
         end
         if (acc) push_word(load_data);
      end
      #1;
   endtask

   task automatic test_reset();
      load_valid = 1'b1;
      load_data  = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if ({val_m, out_m, rdy_m, cnt_m} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            fails++;
            $display("FAIL reset_hold cyc %0d: got v=%b o=%b r=%b n=%0d want v=0 o=1 r=1 n=0",
                     i, val_m, out_m, rdy_m, cnt_m);
         end
      end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL reset_release cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
      end
   endtask

   task automatic test_single_msb();
      logic [31:0] cap = '0;
      int          n   = 0;
      load_valid = 1'b1;
      load_data  = 8'h66;
      for (int i = 0; i < 14; i++) begin
         step();
         load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL single_msb cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
         if (val_m && n < 8) begin
            cap = {cap[30:0], out_m};
            n++;
         end
      end
      tests++;
      if (cap[7:0] !== 8'h66 || cnt_m !== 16'd2) begin
         fails++;
         $display("FAIL single_msb_bits: got bits %h n=%0d want 66 n=2", cap[7:0], cnt_m);
      end
   endtask

   task automatic test_single_lsb();
      logic [31:0] cap = '0;
      int          n   = 0;
      load_valid = 1'b1;
      load_data  = 8'h01;
      for (int i = 0; i < 14; i++) begin
         step();
         load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL single_lsb cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
         if (val_l && n < 8) begin
            cap = {cap[30:0], out_l};
            n++;
         end
      end
      tests++;
      if (cap[7:0] !== 8'h80 || cnt_l !== 16'd3) begin
         fails++;
         $display("FAIL single_lsb_bits: got bits %h n=%0d want 80 n=3", cap[7:0], cnt_l);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] cap = '0;
      logic [31:0] want;
`ifdef SERIAL_FEEDER_PARITY_EN
      want = {14'd0, 8'hA5, 1'b0, 8'h3C, 1'b0};
`else
      want = {16'd0, 8'hA5, 8'h3C};
`endif
      load_valid = 1'b1;
      load_data  = 8'hA5;
      for (int i = 0; i < 26; i++) begin
         step();
         if (i == 0) load_data = 8'h3C;
         else        load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
         if (val_m) cap = {cap[30:0], out_m};
      end
      tests++;
      if (cap !== want || cnt_m !== 16'd5) begin
         fails++;
         $display("FAIL back_to_back_bits: got %h n=%0d want %h n=5", cap, cnt_m, want);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] cap = '0;
      int          n   = 0;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         load_valid = 1'b0;
      end
      #2;
      reset = 1'b0;
      q.delete();
      m_words = 16'd0;
      #1;
      tests++;
      if ({val_m, out_m, rdy_m, busy_m, cnt_m} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
         fails++;
         $display("FAIL async_reset: got v=%b o=%b r=%b b=%b n=%0d want v=0 o=1 r=1 b=0 n=0",
                  val_m, out_m, rdy_m, busy_m, cnt_m);
      end
      @(negedge clock);
      reset = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h0F;
      for (int i = 0; i < 14; i++) begin
         step();
         load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL after_reset cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
         if (val_m && n < 8) begin
            cap = {cap[30:0], out_m};
            n++;
         end
      end
      tests++;
      if (cap[7:0] !== 8'h0F || cnt_m !== 16'd1) begin
         fails++;
         $display("FAIL after_reset_bits: got %h n=%0d want 0f n=1", cap[7:0], cnt_m);
      end
   endtask

`ifdef SERIAL_FEEDER_PARITY_EN
   task automatic test_parity();
      logic [31:0] cap = '0;
      logic [31:0] want;
      want = {14'd0, 8'h07, 1'b1, 8'h03, 1'b0};
      load_valid = 1'b1;
      load_data  = 8'h07;
      for (int i = 0; i < 26; i++) begin
         step();
         if (i == 0) load_data = 8'h03;
         else        load_valid = 1'b0;
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL parity cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
         if (val_m) cap = {cap[30:0], out_m};
      end
      tests++;
      if (cap !== want) begin
         fails++;
         $display("FAIL parity_bits: got %h want %h", cap, want);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = W'($urandom);
         step();
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
      end
      load_valid = 1'b0;
      for (int i = 0; i < 60 && q.size() > 0; i++) begin
         step();
         tests++;
         if (obs_now() !== exp_now()) begin
            fails++;
            $display("FAIL drain cyc %0d: got %h want %h", i, obs_now(), exp_now());
         end
      end
      step();
      tests++;
      if ({busy_m, busy_l, val_m, val_l} !== 4'b0000 || cnt_m !== m_words) begin
         fails++;
         $display("FAIL drain_idle: got busy=%b%b valid=%b%b n=%0d want 0000 n=%0d",
                  busy_m, busy_l, val_m, val_l, cnt_m, m_words);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clock      = 1'b0;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      m_words    = 16'd0;
      tests      = 0;
      fails      = 0;
      test_reset();
      test_single_msb();
      test_single_lsb();
      test_back_to_back();
      test_reset_midframe();
`ifdef SERIAL_FEEDER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
